// File: rtl/ether_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ether_pkg
// Brief    : Shared types and constants for the Ethernet transmit framer:
//            state encoding, preamble/SFD bytes and CRC-32 parameters.
// Revision : 1.0 - initial release
// ============================================================================
package ether_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    PAYLOAD  = 3'd3,
    PAD      = 3'd4,
    FCS      = 3'd5,
    IFG      = 3'd6
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam int          FCS_LEN       = 4;

  // Bit-reverse a 32-bit word; the line CRC runs LSB-first, so the
  // polynomial is applied in reflected form.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ether_tx_framer_crc32_byte.sv
`default_nettype none
// ============================================================================
// Module   : crc32_byte
// Brief    : Combinational single-byte step of the reflected Ethernet CRC-32.
//            The caller owns the CRC state register. Only built when
//            ETHER_TX_FCS_EN is defined; without it the framer has no CRC.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef ETHER_TX_FCS_EN
module crc32_byte
  import ether_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] c_POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] crc_v;

  // Fold the byte in, then shift out eight bits LSB-first.
  always_comb begin
    crc_v = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_v = crc_v[0] ? ((crc_v >> 1) ^ c_POLY_REFL) : (crc_v >> 1);
    end
    crc_o = crc_v;
  end

endmodule
`endif
`default_nettype wire

// File: rtl/ether_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : ether_tx_framer
// Brief    : Byte-stream to RMII/MII line framer. Adds preamble and SFD,
//            zero-pads short payloads, optionally appends the CRC-32 FCS
//            and enforces the inter-frame gap.
//            Build option: define ETHER_TX_FCS_EN to include FCS generation.
// Revision : 1.0 - initial release
// ============================================================================
module ether_tx_framer
  import ether_pkg::*;
#(
  parameter int DW        = 2,
  parameter int MIN_BYTES = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic          axiov,
  output logic [DW-1:0] axiod,
  output logic          busy,
  output logic          tx_err
);

  localparam int          c_CPB         = 8 / DW;
  localparam int          c_IFG_CYC_RAW = (IFG_BYTES * 8) / DW;
  localparam int          c_IFG_CYC     = (c_IFG_CYC_RAW < 1) ? 1 : c_IFG_CYC_RAW;
  localparam logic [1:0]  c_LAST_PHASE  = 2'(c_CPB - 1);
  localparam logic [3:0]  c_DW          = 4'(DW);
  localparam logic [15:0] c_IFG_LAST    = 16'(c_IFG_CYC - 1);
  localparam logic [10:0] c_CNT_MAX     = 11'h7FF;
  localparam logic [11:0] c_MIN         = 12'(MIN_BYTES);
  localparam logic [2:0]  c_PRE_LAST    = 3'(PREAMBLE_LEN - 1);
`ifdef ETHER_TX_FCS_EN
  localparam logic [2:0]  c_FCS_LAST    = 3'(FCS_LEN - 1);
  localparam tx_state_e   c_AFTER_BODY  = FCS;
`else
  localparam tx_state_e   c_AFTER_BODY  = IFG;
`endif

  if (DW != 2 && DW != 4) begin : g_dw_check
    $error("ether_tx_framer: DW must be 2 or 4");
  end

  tx_state_e   state_q, state_d;
  logic [1:0]  phase_q, phase_d;   // chunk index within the current byte
  logic [2:0]  idx_q,   idx_d;     // byte index within PREAMBLE / FCS
  logic [10:0] cnt_q,   cnt_d;     // payload+pad bytes, saturating
  logic [7:0]  data_q,  data_d;    // payload byte currently on the line
  logic        last_q,  last_d;    // data_q is the final payload byte
  logic [15:0] ifg_q,   ifg_d;     // gap cycle counter

  logic        w_last_phase;
  logic [10:0] w_cnt_inc;
  logic        w_below_min;
  logic [7:0]  w_line_byte;

`ifdef ETHER_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] w_crc_next;
  logic [7:0]  w_fcs_byte;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (w_line_byte),
    .crc_o  (w_crc_next)
  );

  assign w_fcs_byte = ~8'(crc_q >> {idx_q[1:0], 3'b000});
`endif

  assign w_last_phase = (phase_q == c_LAST_PHASE);
  assign w_cnt_inc    = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 11'd1;
  assign w_below_min  = ({1'b0, w_cnt_inc} < c_MIN);

  assign axiov   = (state_q != IDLE) && (state_q != IFG);
  assign busy    = (state_q != IDLE);
  assign s_ready = w_last_phase && ((state_q == SFD) || ((state_q == PAYLOAD) && !last_q));
  // A missing byte at the SFD handoff is treated like any other underrun.
  assign tx_err  = s_ready && !s_valid;

  // Select the byte currently being serialised onto the line.
  always_comb begin
    w_line_byte = 8'h00;
    case (state_q)
      PREAMBLE: w_line_byte = PREAMBLE_BYTE;
      SFD:      w_line_byte = SFD_BYTE;
      PAYLOAD:  w_line_byte = data_q;
`ifdef ETHER_TX_FCS_EN
      FCS:      w_line_byte = w_fcs_byte;
`endif
      default:  w_line_byte = 8'h00;
    endcase
  end

  // Serialise the line byte LSB-first, DW bits per cycle; quiet when idle.
  always_comb begin
    axiod = '0;
    if (axiov) begin
      axiod = DW'(w_line_byte >> ({2'b00, phase_q} * c_DW));
    end
  end

  // Next-state and datapath update for the framer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    ifg_d   = ifg_q;
`ifdef ETHER_TX_FCS_EN
    crc_d   = crc_q;
`endif
    if (axiov) begin
      phase_d = w_last_phase ? 2'd0 : phase_q + 2'd1;
    end
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = PREAMBLE;
          phase_d = 2'd0;
          idx_d   = 3'd0;
          cnt_d   = 11'd0;
          last_d  = 1'b0;
`ifdef ETHER_TX_FCS_EN
          crc_d   = CRC_INIT;
`endif
        end
      end
      PREAMBLE: begin
        if (w_last_phase) begin
          if (idx_q == c_PRE_LAST) begin
            state_d = SFD;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      SFD: begin
        if (w_last_phase) begin
          if (s_valid) begin
            data_d  = s_data;
            last_d  = s_last;
            state_d = PAYLOAD;
          end else begin
            state_d = IFG;
            ifg_d   = 16'd0;
          end
        end
      end
      PAYLOAD: begin
        if (w_last_phase) begin
          cnt_d = w_cnt_inc;
`ifdef ETHER_TX_FCS_EN
          crc_d = w_crc_next;
`endif
          if (last_q) begin
            state_d = w_below_min ? PAD : c_AFTER_BODY;
            idx_d   = 3'd0;
            ifg_d   = 16'd0;
          end else if (s_valid) begin
            data_d = s_data;
            last_d = s_last;
          end else begin
            // Underrun: the current byte is complete, abandon the frame.
            state_d = IFG;
            ifg_d   = 16'd0;
          end
        end
      end
      PAD: begin
        if (w_last_phase) begin
          cnt_d = w_cnt_inc;
`ifdef ETHER_TX_FCS_EN
          crc_d = w_crc_next;
`endif
          if (!w_below_min) begin
            state_d = c_AFTER_BODY;
            idx_d   = 3'd0;
            ifg_d   = 16'd0;
          end
        end
      end
`ifdef ETHER_TX_FCS_EN
      FCS: begin
        if (w_last_phase) begin
          if (idx_q == c_FCS_LAST) begin
            state_d = IFG;
            ifg_d   = 16'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`endif
      IFG: begin
        if (ifg_q == c_IFG_LAST) begin
          state_d = IDLE;
        end else begin
          ifg_d = ifg_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 11'd0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      ifg_q   <= 16'd0;
`ifdef ETHER_TX_FCS_EN
      crc_q   <= CRC_INIT;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ifg_q   <= ifg_d;
`ifdef ETHER_TX_FCS_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ether_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ether_tx_framer
// Brief    : Directed self-checking bench for ether_tx_framer. Three DUT
//            instances (RMII/MIN 60, MII/MIN 60, RMII/no padding) share the
//            clock, reset and stimulus; one is selected per test.
//            Honours ETHER_TX_FCS_EN for the expected frame contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ether_tx_framer;

`ifdef ETHER_TX_FCS_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] drv_data  = 8'h00;
  logic       drv_valid = 1'b0;
  logic       drv_last  = 1'b0;
  int         sel = 0;

  logic       v_a, v_b, v_c;
  logic       r_a, r_b, r_c, ov_a, ov_b, ov_c, b_a, b_b, b_c, e_a, e_b, e_c;
  logic [1:0] od_a, od_c;
  logic [3:0] od_b;

  logic       m_ready, m_v, m_busy, m_err;
  logic [3:0] m_d;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] payload [0:127];
  logic [7:0] line_q [$];

  always #5 clk = ~clk;

  assign v_a = (sel == 0) ? drv_valid : 1'b0;
  assign v_b = (sel == 1) ? drv_valid : 1'b0;
  assign v_c = (sel == 2) ? drv_valid : 1'b0;

  ether_tx_framer #(.DW(2), .MIN_BYTES(60), .IFG_BYTES(12)) dut_a (
    .clk(clk), .rst(rst), .s_data(drv_data), .s_valid(v_a), .s_last(drv_last),
    .s_ready(r_a), .axiov(ov_a), .axiod(od_a), .busy(b_a), .tx_err(e_a));

  ether_tx_framer #(.DW(4), .MIN_BYTES(60), .IFG_BYTES(12)) dut_b (
    .clk(clk), .rst(rst), .s_data(drv_data), .s_valid(v_b), .s_last(drv_last),
    .s_ready(r_b), .axiov(ov_b), .axiod(od_b), .busy(b_b), .tx_err(e_b));

  ether_tx_framer #(.DW(2), .MIN_BYTES(0), .IFG_BYTES(12)) dut_c (
    .clk(clk), .rst(rst), .s_data(drv_data), .s_valid(v_c), .s_last(drv_last),
    .s_ready(r_c), .axiov(ov_c), .axiod(od_c), .busy(b_c), .tx_err(e_c));

  // Route the selected instance's outputs to the monitor.
  always_comb begin
    m_ready = r_a; m_v = ov_a; m_busy = b_a; m_err = e_a; m_d = {2'b00, od_a};
    if (sel == 1) begin
      m_ready = r_b; m_v = ov_b; m_busy = b_b; m_err = e_b; m_d = od_b;
    end else if (sel == 2) begin
      m_ready = r_c; m_v = ov_c; m_busy = b_c; m_err = e_c; m_d = {2'b00, od_c};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Drive one frame of len bytes (only n_send offered) and capture the line.
  task automatic run_frame(input int dw, input int len, input int n_send, input int rst_at,
                           output int on_cyc, output int rises, output int ifg_cyc,
                           output int errs, output int rdys);
    int idx, cyc, bitpos;
    logic [31:0] acc, chunk;
    logic took, prev_v, seen_busy, done;
    line_q.delete();
    idx = 0; cyc = 0; bitpos = 0; acc = 0;
    took = 0; prev_v = 0; seen_busy = 0; done = 0;
    on_cyc = 0; rises = 0; ifg_cyc = 0; errs = 0; rdys = 0;
    @(negedge clk);
    while (!done && cyc < 4000) begin
      if (took) idx++;
      drv_valid = (idx < n_send);
      drv_data  = (idx < len) ? payload[idx] : 8'h00;
      drv_last  = (idx == len - 1);
      #1;
      took = m_ready && drv_valid;
      if (m_ready) rdys++;
      if (m_err) errs++;
      if (m_v) begin
        on_cyc++;
        if (!prev_v) rises++;
        chunk  = 32'(m_d) & ((32'd1 << dw) - 32'd1);
        acc    = acc | (chunk << bitpos);
        bitpos = bitpos + dw;
        if (bitpos == 8) begin
          line_q.push_back(acc[7:0]);
          acc = 0;
          bitpos = 0;
        end
      end
      if (m_busy && !m_v) ifg_cyc++;
      if (m_busy) seen_busy = 1;
      else if (seen_busy) done = 1;
      prev_v = m_v;
      if (rst_at >= 0 && on_cyc == rst_at && m_v) begin
        rst = 1'b1;
        #1;
        check("rst_axiov", 32'(m_v), 0);
        check("rst_axiod", 32'(m_d), 0);
        check("rst_busy", 32'(m_busy), 0);
        check("rst_ready", 32'(m_ready), 0);
        check("rst_err", 32'(m_err), 0);
        drv_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        done = 1;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    check("frame_done", 32'(done), 1);
  endtask

  function automatic int hdr_bad();
    int bad = 0;
    for (int i = 0; i < 7; i++) if (line_q[i] !== 8'h55) bad++;
    if (line_q[7] !== 8'hD5) bad++;
    return bad;
  endfunction

  function automatic int body_bad(input int len);
    int bad = 0;
    for (int i = 0; i < len; i++) if (line_q[8+i] !== payload[i]) bad++;
    return bad;
  endfunction

`ifdef ETHER_TX_FCS_EN
  // Compare the four FCS bytes after body_len bytes of payload+pad.
  task automatic check_fcs(input string tag, input int len, input int body_len);
    logic [31:0] crc, fcs, got;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < body_len; i++) crc = crc_step(crc, (i < len) ? payload[i] : 8'h00);
    fcs = ~crc;
    got = {line_q[8+body_len+3], line_q[8+body_len+2], line_q[8+body_len+1], line_q[8+body_len]};
    check(tag, got, fcs);
  endtask
`endif

  initial begin
    int on, rs, ifg, er, rd, bad;
    sel = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_axiov", 32'(m_v), 0);
    check("reset_axiod", 32'(m_d), 0);
    check("reset_ready", 32'(m_ready), 0);
    check("reset_busy", 32'(m_busy), 0);
    check("reset_err", 32'(m_err), 0);
    rst = 1'b0;

    // 60-byte frame on RMII: exactly the minimum, no pad.
    for (int i = 0; i < 128; i++) payload[i] = 8'(i * 7 + 3);
    sel = 0;
    run_frame(2, 60, 60, -1, on, rs, ifg, er, rd);
    check("t1_on_cycles", on, 32'(272 + 16 * F));
    check("t1_one_burst", rs, 1);
    check("t1_ifg_cycles", ifg, 48);
    check("t1_tx_err", er, 0);
    check("t1_ready_pulses", rd, 60);
    check("t1_line_bytes", line_q.size(), 32'(68 + 4 * F));
    check("t1_header_bad", hdr_bad(), 0);
    check("t1_payload_bad", body_bad(60), 0);
`ifdef ETHER_TX_FCS_EN
    check_fcs("t1_fcs", 60, 60);
`endif

    // "123456789" with padding disabled: check value for the CRC.
    for (int i = 0; i < 9; i++) payload[i] = 8'(8'h31 + i);
    sel = 2;
    run_frame(2, 9, 9, -1, on, rs, ifg, er, rd);
    check("t2_on_cycles", on, 32'(68 + 16 * F));
    check("t2_line_bytes", line_q.size(), 32'(17 + 4 * F));
    check("t2_payload_bad", body_bad(9), 0);
`ifdef ETHER_TX_FCS_EN
    check("t2_fcs0", 32'(line_q[17]), 32'h26);
    check("t2_fcs1", 32'(line_q[18]), 32'h39);
    check("t2_fcs2", 32'(line_q[19]), 32'hF4);
    check("t2_fcs3", 32'(line_q[20]), 32'hCB);
`endif

    // 10-byte frame on MII: 50 zero pad bytes.
    for (int i = 0; i < 10; i++) payload[i] = 8'(8'hA0 + i * 3);
    sel = 1;
    run_frame(4, 10, 10, -1, on, rs, ifg, er, rd);
    check("t3_on_cycles", on, 32'(136 + 8 * F));
    check("t3_ifg_cycles", ifg, 24);
    check("t3_line_bytes", line_q.size(), 32'(68 + 4 * F));
    check("t3_payload_bad", body_bad(10), 0);
    bad = 0;
    for (int i = 18; i < 68; i++) if (line_q[i] !== 8'h00) bad++;
    check("t3_pad_bad", bad, 0);
`ifdef ETHER_TX_FCS_EN
    check_fcs("t3_fcs", 10, 60);
`endif

    // Underrun at the 5th s_ready pulse.
    for (int i = 0; i < 128; i++) payload[i] = 8'(i * 13 + 1);
    sel = 0;
    run_frame(2, 10, 4, -1, on, rs, ifg, er, rd);
    check("t4_tx_err", er, 1);
    check("t4_ready_pulses", rd, 5);
    check("t4_line_bytes", line_q.size(), 12);
    check("t4_on_cycles", on, 48);
    check("t4_ifg_cycles", ifg, 48);
    check("t4_payload_bad", body_bad(4), 0);

    // Reset in the middle of the payload, then a clean frame.
    run_frame(2, 60, 60, 132, on, rs, ifg, er, rd);
    run_frame(2, 60, 60, -1, on, rs, ifg, er, rd);
    check("t5_on_cycles", on, 32'(272 + 16 * F));
    check("t5_header_bad", hdr_bad(), 0);
    check("t5_payload_bad", body_bad(60), 0);
`ifdef ETHER_TX_FCS_EN
    check_fcs("t5_fcs", 60, 60);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ether_tx_framer.md
ETHER_TX_FRAMER -- requirements
Module: ether_tx_framer

Interface
REQ-001 Parameter DW, default 2, output bits per cycle; legal values 2 (RMII dibit) and 4 (MII nibble).
REQ-002 Parameter MIN_BYTES, default 60, minimum payload length in bytes before FCS; shorter frames are zero-padded; 0 disables padding.
REQ-003 Parameter IFG_BYTES, default 12, inter-frame gap in byte times.
REQ-004 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_data  input  8  payload byte.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_last  input  1  s_data is final payload byte of frame.
REQ-009 s_ready  output  1  byte accepted this cycle when s_valid&s_ready.
REQ-010 axiov  output  1  line data valid (TX_EN).
REQ-011 axiod  output  DW  line data, LSB-first.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tx_err  output  1  one-cycle pulse on payload underrun.

Function
REQ-014 States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
REQ-015 One byte occupies 8/DW cycles; bits leave LSB-first, DW bits per cycle.
REQ-016 IDLE: axiov=0, axiod=0, s_ready=0; s_valid=1 moves to PREAMBLE next cycle, with the first preamble chunk on axiod in that cycle.
REQ-017 PREAMBLE sends 7 bytes 0x55; SFD sends 1 byte 0xD5.
REQ-018 s_ready pulses high for exactly one cycle: the last cycle of the SFD byte and the last cycle of each non-final payload byte. The byte is sampled at that edge and sent from the next cycle.
REQ-019 If s_valid=0 while s_ready=1 in PAYLOAD (underrun): pulse tx_err, finish the current byte, skip PAD and FCS, go to IFG.
REQ-020 After the s_last byte: if payload count < MIN_BYTES go to PAD and send 0x00 until the count equals MIN_BYTES, else go to FCS.
REQ-021 FCS: CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, final complement) over payload plus pad bytes; 4 bytes sent least-significant byte first.
REQ-022 IFG: axiov=0 for IFG_BYTES*8/DW cycles, then IDLE; s_valid is ignored during IFG.
REQ-023 axiov=1 in PREAMBLE through FCS inclusive, with no gaps; axiod=0 whenever axiov=0.
REQ-024 Payload byte counter is 11 bits and saturates at 2047; frames longer than that are still sent unmodified.
REQ-025 s_last together with an underrun cannot occur, because underrun requires s_valid=0.

Reset
REQ-026 rst asserted, including mid-frame: immediately axiov=0, axiod=0, s_ready=0, busy=0, tx_err=0; state IDLE; counters and CRC cleared.
REQ-027 First frame after rst deassertion needs no gap.

Configuration
REQ-028 Macro ETHER_TX_FCS_EN defined: FCS state and CRC logic built, per REQ-021.
REQ-029 ETHER_TX_FCS_EN undefined: no CRC logic; PAYLOAD/PAD proceed directly to IFG and the frame carries no FCS.

Structure
REQ-030 Package ether_pkg holds the state enum, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_LEN=7, CRC_POLY, CRC_INIT and FCS_LEN=4.
REQ-031 Sub-module crc32_byte: combinational next-CRC from current CRC and one byte; the framer registers the CRC state.

Verification
REQ-032 DW=2, MIN_BYTES=60, 60-byte frame, s_valid held high -> axiov high for 288 consecutive cycles (32 preamble/SFD, 240 payload, 16 FCS), then low for 48 cycles.
REQ-033 MIN_BYTES=0, payload ASCII "123456789", FCS_EN defined -> FCS bytes on the line are 0x26, 0x39, 0xF4, 0xCB in that order.
REQ-034 DW=4, MIN_BYTES=60, 10-byte frame -> 50 pad bytes of 0x00; axiov high for 16+120+8=144 cycles.
REQ-035 s_valid dropped at the 5th s_ready pulse -> tx_err pulses once, 4 payload bytes sent, no FCS, IFG follows.
REQ-036 rst pulsed at payload cycle 100 -> axiov=0 in the same cycle; a new frame after release starts with 0x55 preamble and correct FCS.
REQ-037 FCS_EN undefined, DW=2, 60-byte frame -> axiov high 272 cycles.
